// File: rtl/correlator_bank_if.sv
// Result port of the correlator bank: winning channel, its signed
// accumulator and the detection flag, offered with a valid/ready handshake.
interface correlator_bank_if #(
  parameter int CH_W  = 3,
  parameter int ACC_W = 16
) ();
  logic                    result_valid;
  logic                    result_ready;
  logic [CH_W-1:0]         best_ch;
  logic signed [ACC_W-1:0] best_acc;
  logic                    detect;

  modport master (output result_valid, best_ch, best_acc, detect, input result_ready);
  modport slave  (input result_valid, best_ch, best_acc, detect, output result_ready);
endinterface

// File: rtl/correlator_bank.sv
// Multi-channel 1-bit correlator: phase-shifted square-wave codes are correlated
// against sig over a window, then the channel with the largest |acc| is reported.
module correlator_bank #(
  parameter int CHANNELS = 8,
  parameter int ACC_W    = 16,
  parameter int PERIOD_W = 20,
  parameter int WINDOW_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig,
  input  logic [PERIOD_W-1:0] half_period,
  input  logic [PERIOD_W-1:0] phase_step,
  input  logic [WINDOW_W-1:0] window,
  input  logic [ACC_W-2:0]    threshold,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  correlator_bank_if.master   res
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (WINDOW_W > CH_W + 1) ? WINDOW_W : CH_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [PERIOD_W:0]       CTR_ONE = (PERIOD_W+1)'(1);

  typedef enum logic [2:0] {IDLE, ARM, RUN, SEARCH, HOLD} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic [CH_W-1:0]         idx;
  logic [PERIOD_W-1:0]     hp_q, step_q;
  logic [WINDOW_W-1:0]     win_q;
  logic [ACC_W-2:0]        thr_q;
  logic [PERIOD_W:0]       two_hp, phase, phase_nxt;
  logic [PERIOD_W+1:0]     phase_sum;
  logic [PERIOD_W:0]       ctr [CHANNELS];
  logic signed [ACC_W-1:0] acc [CHANNELS];
  logic [CH_W-1:0]         cand_ch, best_ch_q;
  logic signed [ACC_W-1:0] cand_acc, best_acc_q;
  logic                    detect_q, valid;
  logic                    last_arm, last_run, last_search;

  function automatic logic [ACC_W-1:0] magnitude(input logic signed [ACC_W-1:0] a);
    return a[ACC_W-1] ? -a : a;
  endfunction

  assign idx         = cnt[CH_W-1:0];
  assign last_arm    = (cnt == CNT_W'(CHANNELS - 1));
  assign last_run    = (cnt == CNT_W'(win_q) - CNT_W'(1));
  assign last_search = (cnt == CNT_W'(CHANNELS));
  assign two_hp      = {hp_q, 1'b0};
  assign phase_sum   = {1'b0, phase} + {2'b00, step_q};
  assign phase_nxt   = (phase_sum >= {1'b0, two_hp}) ? (PERIOD_W+1)'(phase_sum - {1'b0, two_hp})
                                                     : phase_sum[PERIOD_W:0];

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !abort)  state_nxt = ARM;
      ARM:     if (last_arm)         state_nxt = RUN;
      RUN:     if (last_run)         state_nxt = SEARCH;
      SEARCH:  if (last_search)      state_nxt = HOLD;
      HOLD:    if (res.result_ready) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == HOLD);
  end

  // SEARCH runs one step past the last channel: that final edge publishes the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      hp_q       <= '0;
      step_q     <= '0;
      win_q      <= '0;
      thr_q      <= '0;
      phase      <= '0;
      cand_ch    <= '0;
      cand_acc   <= '0;
      best_ch_q  <= '0;
      best_acc_q <= '0;
      detect_q   <= 1'b0;
      // NOTE: ctr/acc are flop arrays, not RAM, so they take the async reset too.
      for (int i = 0; i < CHANNELS; i++) begin
        ctr[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      case (state)
        IDLE: if (state_nxt == ARM) begin
          hp_q   <= (half_period == '0) ? PERIOD_W'(1) : half_period;
          step_q <= phase_step;
          win_q  <= (window == '0) ? WINDOW_W'(1) : window;
          thr_q  <= threshold;
          phase  <= '0;
          for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end
        ARM: begin
          ctr[idx] <= phase;
          phase    <= phase_nxt;
        end
        RUN: for (int i = 0; i < CHANNELS; i++) begin
          if (sig == (ctr[i] >= {1'b0, hp_q})) begin
            if (acc[i] != ACC_MAX) acc[i] <= acc[i] + ACC_ONE;
          end else begin
            if (acc[i] != ACC_MIN) acc[i] <= acc[i] - ACC_ONE;
          end
          ctr[i] <= (ctr[i] == two_hp - CTR_ONE) ? '0 : ctr[i] + CTR_ONE;
        end
        SEARCH: if (last_search) begin
          if (state_nxt == HOLD) begin
            best_ch_q  <= cand_ch;
            best_acc_q <= cand_acc;
            detect_q   <= (magnitude(cand_acc) >= {1'b0, thr_q});
          end
        end else if (cnt == '0 || magnitude(acc[idx]) > magnitude(cand_acc)) begin
          cand_ch  <= idx;
          cand_acc <= acc[idx];
        end
        default: ;
      endcase
    end
  end

  assign res.result_valid = valid;
  assign res.best_ch      = best_ch_q;
  assign res.best_acc     = best_acc_q;
  assign res.detect       = detect_q;
endmodule

// File: tb/tb_correlator_bank.sv
// Self-checking bench for correlator_bank: directed scenarios plus randomized
// runs compared against an arithmetic model of the correlation and search.
module tb_correlator_bank;
  localparam int C = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig = 1'b0;
  logic [19:0] half_period = '0;
  logic [19:0] phase_step = '0;
  logic [15:0] window = '0;
  logic [14:0] threshold = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic        busy, busy_s;

  int n_cmp = 0;
  int n_mis = 0;
  bit seq [0:511];
  int win_e;

  always #5 clk = ~clk;

  correlator_bank_if #(.CH_W(3), .ACC_W(16)) res ();
  correlator_bank_if #(.CH_W(3), .ACC_W(8))  res_s ();
  assign res.result_ready   = ready;
  assign res_s.result_ready = ready;

  correlator_bank #(.CHANNELS(C), .ACC_W(16), .PERIOD_W(20), .WINDOW_W(16)) dut (
    .clk(clk), .rst(rst), .sig(sig), .half_period(half_period), .phase_step(phase_step),
    .window(window), .threshold(threshold), .start(start), .abort(abort), .busy(busy), .res(res)
  );

  correlator_bank #(.CHANNELS(C), .ACC_W(8), .PERIOD_W(20), .WINDOW_W(16)) dut_s (
    .clk(clk), .rst(rst), .sig(sig), .half_period(half_period), .phase_step(phase_step),
    .window(window), .threshold(threshold[6:0]), .start(start), .abort(abort), .busy(busy_s),
    .res(res_s)
  );

  // Channel k's code at window sample j is ((k*step + j) mod 2h) >= h; strict > keeps lowest index.
  function automatic void model(input int hp, input int step, input int acc_max,
                                output int e_ch, output int e_acc);
    int h2, p, a, best;
    h2 = 2 * ((hp == 0) ? 1 : hp);
    best = -1; e_ch = 0; e_acc = 0;
    for (int k = 0; k < C; k++) begin
      p = (k * step) % h2;
      a = 0;
      for (int j = 0; j < win_e; j++) begin
        a += (seq[j] == (((p + j) % h2) >= h2 / 2)) ? 1 : -1;
        if (a > acc_max)  a = acc_max;
        if (a < -acc_max) a = -acc_max;
      end
      if ((a < 0 ? -a : a) > best) begin
        best = (a < 0) ? -a : a; e_ch = k; e_acc = a;
      end
    end
  endfunction

  task automatic rand_cfg(output int hp, output int step, output int win, output int thr);
    int h;
    hp = $urandom_range(6, 0);
    h = (hp == 0) ? 1 : hp;
    step = $urandom_range(2 * h - 1, 0);
    win = $urandom_range(40, 0);
    thr = $urandom_range(20, 0);
  endtask

  // mode: 0 random, 1 channel-3 code, 2 inverted channel-3 code, 3 all zero.
  // cut_c > 0 aborts (or resets, if cut_rst) on that cycle after start.
  task automatic run_meas(input int hp, input int step, input int win, input int thr,
                          input int mode, input int cut_c, input bit cut_rst,
                          output int lat, output bit busy1);
    int h, p3, j;
    h = (hp == 0) ? 1 : hp;
    win_e = (win == 0) ? 1 : win;
    p3 = (3 * step) % (2 * h);
    for (int i = 0; i < win_e; i++) begin
      case (mode)
        0:       seq[i] = 1'($urandom);
        1:       seq[i] = (((p3 + i) % (2 * h)) >= h);
        2:       seq[i] = !(((p3 + i) % (2 * h)) >= h);
        default: seq[i] = 1'b0;
      endcase
    end
    @(negedge clk);
    half_period = 20'(hp); phase_step = 20'(step); window = 16'(win); threshold = 15'(thr);
    start = 1'b1;
    @(posedge clk);
    lat = -1; busy1 = 1'b0;
    for (int c = 1; c <= 2 * C + win_e + 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      half_period = 20'($urandom); phase_step = 20'($urandom);
      window = 16'($urandom); threshold = 15'($urandom);
      j = c - C - 1;
      sig = (j >= 0 && j < win_e) ? seq[j] : 1'($urandom);
      if (c == cut_c && cut_rst) begin
        #2 rst = 1'b0;
        #1 lat = c;
        break;
      end
      if (c == cut_c) abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      if (c == 1) busy1 = busy;
      if (c == cut_c || res.result_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, res.result_valid, res.best_ch, res.best_acc, res.detect} !== '0) begin
      n_mis++; $display("FAIL reset_outputs: got %h want 0", {busy, res.result_valid, res.best_ch, res.best_acc, res.detect});
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, res.result_valid} !== 2'b00) begin
      n_mis++; $display("FAIL reset_release_idle: got %b want 00", {busy, res.result_valid});
    end
  endtask

  task automatic test_match();
    int lat; bit b1;
    run_meas(4, 1, 64, 32, 1, -1, 1'b0, lat, b1);
    n_cmp++;
    if (lat !== 2 * C + 64 + 1) begin n_mis++; $display("FAIL match_latency: got %0d want %0d", lat, 2 * C + 65); end
    n_cmp++;
    if (b1 !== 1'b1) begin n_mis++; $display("FAIL match_busy_after_start: got %b want 1", b1); end
    n_cmp++;
    if ({busy, res.best_ch, res.best_acc, res.detect} !== {1'b1, 3'd3, 16'sd64, 1'b1}) begin
      n_mis++; $display("FAIL match_result: got %h want %h", {busy, res.best_ch, res.best_acc, res.detect}, {1'b1, 3'd3, 16'sd64, 1'b1});
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    n_cmp++;
    if ({res.result_valid, busy} !== 2'b00) begin n_mis++; $display("FAIL match_handshake: got %b want 00", {res.result_valid, busy}); end
  endtask

  task automatic test_inverted();
    int lat; bit b1;
    logic signed [15:0] want;
    want = -16'sd64;
    run_meas(4, 1, 64, 32, 2, -1, 1'b0, lat, b1);
    n_cmp++;
    if ({res.best_ch, res.best_acc, res.detect} !== {3'd3, want, 1'b1}) begin
      n_mis++; $display("FAIL inverted_result: got %h want %h", {res.best_ch, res.best_acc, res.detect}, {3'd3, want, 1'b1});
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic test_constant();
    int lat; bit b1;
    run_meas(4, 1, 64, 1, 3, -1, 1'b0, lat, b1);
    n_cmp++;
    if ({res.result_valid, res.best_ch, res.best_acc, res.detect} !== {1'b1, 20'd0}) begin
      n_mis++; $display("FAIL constant_result: got %h want %h", {res.result_valid, res.best_ch, res.best_acc, res.detect}, {1'b1, 20'd0});
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic test_saturation();
    int lat; bit b1;
    run_meas(1000, 0, 300, 100, 3, -1, 1'b0, lat, b1);
    n_cmp++;
    if ({res_s.result_valid, res_s.best_ch, res_s.best_acc, res_s.detect} !== {1'b1, 3'd0, 8'sd127, 1'b1}) begin
      n_mis++; $display("FAIL saturation_acc8: got %h want %h", {res_s.result_valid, res_s.best_ch, res_s.best_acc, res_s.detect}, {1'b1, 3'd0, 8'sd127, 1'b1});
    end
    n_cmp++;
    if ({res.best_ch, res.best_acc, res.detect} !== {3'd0, 16'sd300, 1'b1}) begin
      n_mis++; $display("FAIL saturation_acc16: got %h want %h", {res.best_ch, res.best_acc, res.detect}, {3'd0, 16'sd300, 1'b1});
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int hp, step, win, thr, lat, e_ch, e_acc; bit b1;
    logic [21:0] want;
    rand_cfg(hp, step, win, thr);
    run_meas(hp, step, win, thr, 0, -1, 1'b0, lat, b1);
    model(hp, step, 32767, e_ch, e_acc);
    want = {1'b1, 1'b1, 3'(e_ch), 16'(e_acc), 1'((e_acc < 0 ? -e_acc : e_acc) >= thr)};
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk) start = (cyc == 5);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({res.result_valid, busy, res.best_ch, res.best_acc, res.detect} !== want) begin
        n_mis++; $display("FAIL backpressure_hold cyc %0d: got %h want %h", cyc, {res.result_valid, busy, res.best_ch, res.best_acc, res.detect}, want);
      end
    end
    @(negedge clk);
    ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({res.result_valid, busy} !== 2'b00) begin n_mis++; $display("FAIL backpressure_release: got %b want 00", {res.result_valid, busy}); end
    @(negedge clk);
    ready = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, res.best_ch, res.best_acc, res.detect} !== {1'b0, want[19:0]}) begin
      n_mis++; $display("FAIL backpressure_after: got %h want %h", {busy, res.best_ch, res.best_acc, res.detect}, {1'b0, want[19:0]});
    end
  endtask

  task automatic check_random_run(input string name);
    int hp, step, win, thr, lat, e_ch, e_acc; bit b1;
    logic [19:0] want;
    rand_cfg(hp, step, win, thr);
    run_meas(hp, step, win, thr, 0, -1, 1'b0, lat, b1);
    model(hp, step, 32767, e_ch, e_acc);
    want = {3'(e_ch), 16'(e_acc), 1'((e_acc < 0 ? -e_acc : e_acc) >= thr)};
    n_cmp++;
    if (lat !== 2 * C + win_e + 1) begin n_mis++; $display("FAIL %s_latency: got %0d want %0d", name, lat, 2 * C + win_e + 1); end
    n_cmp++;
    if ({res.best_ch, res.best_acc, res.detect} !== want) begin
      n_mis++; $display("FAIL %s_result hp=%0d step=%0d win=%0d: got %h want %h", name, hp, step, win, {res.best_ch, res.best_acc, res.detect}, want);
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    n_cmp++;
    if ({res.result_valid, busy} !== 2'b00) begin n_mis++; $display("FAIL %s_handshake: got %b want 00", name, {res.result_valid, busy}); end
  endtask

  task automatic test_abort();
    int hp, step, win, thr, lat, seen; bit b1;
    rand_cfg(hp, step, win, thr);
    win = $urandom_range(60, 30);
    run_meas(hp, step, win, thr, 0, C + 21, 1'b0, lat, b1);
    n_cmp++;
    if ({lat, res.result_valid, busy} !== {C + 21, 2'b00}) begin
      n_mis++; $display("FAIL abort_idle: got lat %0d vb %b want lat %0d vb 00", lat, {res.result_valid, busy}, C + 21);
    end
    seen = 0;
    repeat (2 * C + win + 5) begin
      @(posedge clk);
      #1 if (res.result_valid || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_mis++; $display("FAIL abort_no_result: got %0d busy/valid cycles want 0", seen); end
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_mis++; $display("FAIL abort_beats_start: got busy %b want 0", busy); end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_random_run("after_abort");
  endtask

  task automatic test_reset_search();
    int lat; bit b1;
    run_meas(4, 1, 64, 32, 1, -1, 1'b0, lat, b1);
    @(negedge clk) ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    run_meas(4, 1, 30, 5, 0, C + 30 + 3, 1'b1, lat, b1);
    n_cmp++;
    if ({busy, res.result_valid, res.best_ch, res.best_acc, res.detect} !== '0) begin
      n_mis++; $display("FAIL reset_mid_search: got %h want 0", {busy, res.result_valid, res.best_ch, res.best_acc, res.detect});
    end
    @(negedge clk) rst = 1'b1;
    check_random_run("after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) check_random_run("random");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_match();
    test_inverted();
    test_constant();
    test_saturation();
    test_backpressure();
    test_abort();
    test_reset_search();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
